// File: rtl/scan_sequencer.sv
// Channel scanner driving the enable/select of a 3-to-8 decoder stage.
// Optional SCAN_SKIP_EN: honour Mask and skip disabled channels (otherwise all 8 are swept).
module scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Cont,
    input  logic [7:0] Mask,
    output logic       En,
    output logic [2:0] w,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic {S_IDLE, S_DWELL} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      w_q, w_d;
    logic            cont_q, cont_d;
    logic            done_q, done_d;
    logic [7:0]      mask_q;
    logic [7:0]      mask_d;
    logic [7:0]      start_mask;
    logic [7:0]      higher;
    logic            accept;
    logic            last_tick;

    // Lowest set bit; the loop runs high-to-low so the lowest match wins.
    function automatic logic [2:0] lowest(input logic [7:0] m);
        lowest = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest = 3'(i);
    endfunction

`ifdef SCAN_SKIP_EN
    assign start_mask = Mask;

    always_ff @(posedge Clock) begin
        if (Reset) mask_q <= 8'h00;
        else       mask_q <= mask_d;
    end
`else
    logic unused_mask;
    assign unused_mask = ^{Mask, mask_d};
    assign start_mask  = 8'hFF;
    assign mask_q      = 8'hFF;
`endif

    assign accept    = Start && !Stop && (start_mask != 8'h00);
    assign last_tick = (cnt_q == CW'(DWELL - 1));
    // Enabled channels strictly above the current one.
    assign higher    = mask_q & (8'hFE << w_q);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= 3'd0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        cont_d  = cont_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mask_d  = start_mask;
                    cont_d  = Cont;
                    w_d     = lowest(start_mask);
                    cnt_d   = '0;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (Stop) begin
                    state_d = S_IDLE;
                end else if (last_tick) begin
                    cnt_d = '0;
                    if (higher != 8'h00) begin
                        w_d = lowest(higher);
                    end else if (cont_q) begin
                        w_d = lowest(mask_q);
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign En   = (state_q == S_DWELL);
    assign Busy = En;
    assign w    = w_q;
    assign Done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized plus directed bench for scan_sequencer against a channel-list reference model.
module tb_scan_sequencer;
    localparam int DW = 4;

    logic       Clock = 1'b0;
    logic       Reset, Start, Stop, Cont;
    logic [7:0] Mask;
    logic       En, Busy, Done;
    logic [2:0] w;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the sweep is an ordered list of enabled channels.
    bit         m_act, m_cont, m_done;
    logic [2:0] m_w;
    int         m_ch[$];
    int         m_idx, m_tick;

    always #5 Clock = ~Clock;

    scan_sequencer #(.DWELL(DW), .CW(4)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Cont(Cont),
        .Mask(Mask), .En(En), .w(w), .Busy(Busy), .Done(Done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit p, input bit c, input logic [7:0] m);
        logic [7:0] eff;
        if (r) begin
            m_act = 0; m_done = 0; m_w = 3'd0; m_cont = 0; m_ch.delete();
            return;
        end
        m_done = 0;
`ifdef SCAN_SKIP_EN
        eff = m;
`else
        eff = 8'hFF;
`endif
        if (!m_act) begin
            if (s && !p && eff != 8'h00) begin
                m_ch.delete();
                for (int i = 0; i < 8; i++) if (eff[i]) m_ch.push_back(i);
                m_idx = 0; m_tick = 1; m_act = 1; m_cont = c;
                m_w = 3'(m_ch[0]);
            end
        end else if (p) begin
            m_act = 0;
        end else if (m_tick == DW) begin
            m_idx++;
            if (m_idx == m_ch.size()) begin
                if (m_cont) m_idx = 0;
                else begin m_act = 0; m_done = 1; end
            end
            if (m_act) begin
                m_w = 3'(m_ch[m_idx]);
                m_tick = 1;
            end
        end else begin
            m_tick++;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit c, input logic [7:0] m);
        logic [7:0] y_dut, y_exp;
        Reset = r; Start = s; Stop = p; Cont = c; Mask = m;
        @(posedge Clock);
        model_step(r, s, p, c, m);
        #1;
        y_dut = En ? (8'd1 << w) : 8'd0;
        y_exp = m_act ? (8'd1 << m_w) : 8'd0;
        chk("En", 32'(En), 32'(m_act));
        chk("w", 32'(w), 32'(m_w));
        chk("Busy", 32'(Busy), 32'(m_act));
        chk("Done", 32'(Done), 32'(m_done));
        chk("y", 32'(y_dut), 32'(y_exp));
    endtask

    task automatic idle(input int n, input logic [7:0] m);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, m);
    endtask

    initial begin
        m_act = 0; m_done = 0; m_w = 0; m_cont = 0; m_idx = 0; m_tick = 0;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'hFF);

        // Full single sweep, then a few idle cycles after Done.
        cyc(0, 1, 0, 0, 8'hFF);
        idle(36, 8'hFF);

        // Sparse mask with the Mask input scrambled mid-sweep.
        cyc(0, 1, 0, 0, 8'b1010_0100);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 8'($urandom));

        // Continuous wrap over 0 and 7, stop mid-dwell.
        cyc(0, 1, 0, 1, 8'h81);
        idle(21, 8'h81);
        cyc(0, 0, 1, 1, 8'h81);
        idle(4, 8'h81);

        // Ignore cases: empty mask, Start+Stop, Start while busy.
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'hFF);
        cyc(0, 1, 0, 0, 8'h12);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 8'h41);
        idle(40, 8'h00);

        // Single channel continuous, then Reset mid-dwell with Start high.
        cyc(0, 1, 0, 1, 8'h10);
        idle(10, 8'h00);
        cyc(1, 1, 0, 1, 8'h10);
        cyc(0, 1, 0, 0, 8'h0C);
        idle(5, 8'h00);

        // Start held high: a new sweep is accepted in the Done cycle.
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0, 8'h03);
        cyc(0, 0, 1, 0, 8'h03);
        idle(3, 8'h00);

        // Mask 8'h01 single sweep.
        cyc(0, 1, 0, 0, 8'h01);
        idle(36, 8'h00);

        // Random soak.
        for (int i = 0; i < 3000; i++) begin
            bit r, s, p, c;
            logic [7:0] m;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 24) == 0);
            c = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       m = 8'h00;
                1:       m = 8'd1 << $urandom_range(0, 7);
                default: m = 8'($urandom);
            endcase
            cyc(r, s, p, c, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
